// File: rtl/gray_frame_ring.sv
// gray_frame_ring: RGB-to-gray converter with a NUM_FRAMES ring of frame memories that emits co-located history per pixel
module gray_frame_ring #(
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int NUM_FRAMES = 3,
  parameter int ADDR_W     = $clog2(WIDTH*HEIGHT)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_sof,
  input  logic [31:0]                 in_rgb,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [7:0]                  out_gray,
  output logic [8*(NUM_FRAMES-1)-1:0] out_hist,
  output logic [NUM_FRAMES-2:0]       out_hist_valid,
  output logic                        out_eof,
  output logic                        frame_done,
  output logic                        sync_err
);
  localparam int DEPTH = WIDTH*HEIGHT;
  localparam int H     = NUM_FRAMES-1;
  localparam int SW    = $clog2(NUM_FRAMES);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH-1);
  logic [7:0]        mem [NUM_FRAMES][DEPTH];
  logic [7:0]        rd [H];
  logic [ADDR_W-1:0] pix_addr, wa;
  logic [SW-1:0]     wr_slot, hist_count;
  logic [H-1:0]      hv, s1_hv;
  logic [15:0]       sum;
  logic [7:0]        s1_gray;
  logic              s1_valid, s1_eof, stall, acc, resync, last, unused_ok;
  function automatic logic [SW-1:0] hslot(input logic [SW-1:0] s, input int k);
    return SW'((int'(s) + NUM_FRAMES - 1 - k) % NUM_FRAMES);
  endfunction
  assign unused_ok = ^in_rgb[7:0];
  always_comb begin
    stall    = out_valid & ~out_ready;
    in_ready = ~stall;
    acc      = in_valid & in_ready;
    resync   = in_sof && pix_addr != '0;
    wa       = resync ? '0 : pix_addr;
    last     = wa == LAST;
    sum      = 16'(in_rgb[31:24]) * 16'd77 + 16'(in_rgb[23:16]) * 16'd150 + 16'(in_rgb[15:8]) * 16'd29;
    hv       = '0;
    for (int k = 0; k < H; k++) hv[k] = int'(hist_count) > k;
  end
  // History slots always differ from wr_slot, so reading them alongside the write never collides
  always_ff @(posedge clk) begin
    if (rst_n && acc) begin
      mem[wr_slot][wa] <= sum[15:8];
      for (int k = 0; k < H; k++) rd[k] <= mem[hslot(wr_slot, k)][wa];
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pix_addr       <= '0;
      wr_slot        <= '0;
      hist_count     <= '0;
      sync_err       <= 1'b0;
      frame_done     <= 1'b0;
      s1_valid       <= 1'b0;
      s1_gray        <= '0;
      s1_eof         <= 1'b0;
      s1_hv          <= '0;
      out_valid      <= 1'b0;
      out_gray       <= '0;
      out_eof        <= 1'b0;
      out_hist_valid <= '0;
      out_hist       <= '0;
    end else begin
      frame_done <= acc && last;
      if (acc) begin
        sync_err <= sync_err | resync;
        pix_addr <= last ? '0 : wa + 1'b1;
        if (last) begin
          wr_slot    <= wr_slot == SW'(NUM_FRAMES-1) ? '0 : wr_slot + 1'b1;
          hist_count <= hist_count == SW'(H) ? hist_count : hist_count + 1'b1;
        end
      end
      if (!stall) begin
        s1_valid       <= acc;
        s1_gray        <= sum[15:8];
        s1_eof         <= acc && last;
        s1_hv          <= hv;
        out_valid      <= s1_valid;
        out_gray       <= s1_gray;
        out_eof        <= s1_eof;
        out_hist_valid <= s1_hv;
        for (int k = 0; k < H; k++) out_hist[8*k +: 8] <= s1_hv[k] ? rd[k] : 8'd0;
      end
    end
  end
endmodule

// File: tb/tb_gray_frame_ring.sv
// tb_gray_frame_ring: random/directed stimulus checked against a frame-list reference model
module tb_gray_frame_ring;
  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_sof = 1'b0, out_ready = 1'b1;
  logic [31:0] in_rgb = '0;
  logic        in_ready, out_valid, out_eof, frame_done, sync_err;
  logic [7:0]  out_gray;
  logic [15:0] out_hist;
  logic [1:0]  out_hist_valid;
  int checks = 0, failures = 0;
  typedef struct {int win; logic [7:0] g; logic [15:0] h; logic [1:0] hv; logic eof;} beat_t;
  beat_t q[$];
  logic [7:0] cur [8];
  logic [7:0] prev [2][8];
  int win = 0, m_addr = 0, m_cnt = 0;
  logic m_serr = 1'b0, fd_exp = 1'b0;

  gray_frame_ring #(.WIDTH(4), .HEIGHT(2), .NUM_FRAMES(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
    .in_rgb(in_rgb), .out_valid(out_valid), .out_ready(out_ready), .out_gray(out_gray),
    .out_hist(out_hist), .out_hist_valid(out_hist_valid), .out_eof(out_eof),
    .frame_done(frame_done), .sync_err(sync_err));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_accept(input logic sof, input logic [31:0] rgb);
    beat_t b;
    int g;
    g = (int'(rgb[31:24]) * 77 + int'(rgb[23:16]) * 150 + int'(rgb[15:8]) * 29) / 256;
    if (sof && m_addr != 0) begin
      m_serr = 1'b1;
      m_addr = 0;
    end
    b.win = win;
    b.g   = 8'(g);
    b.h   = '0;
    b.hv  = '0;
    for (int k = 0; k < 2; k++) if (m_cnt > k) begin
      b.hv[k] = 1'b1;
      b.h[8*k +: 8] = prev[k][m_addr];
    end
    cur[m_addr] = 8'(g);
    b.eof = m_addr == 7;
    q.push_back(b);
    if (m_addr == 7) begin
      prev[1] = prev[0];
      prev[0] = cur;
      m_cnt   = m_cnt < 2 ? m_cnt + 1 : 2;
      m_addr  = 0;
      fd_exp  = 1'b1;
    end else m_addr++;
  endtask

  task automatic cyc(input logic v, input logic sof, input logic [31:0] rgb, input logic ordy, output logic a);
    logic ev, er;
    in_valid = v; in_sof = sof; in_rgb = rgb; out_ready = ordy;
    @(negedge clk);
    ev = q.size() > 0 && q[0].win + 2 <= win;
    er = !(ev && !ordy);
    a  = v && er && rst_n;
    if (rst_n) begin
      chk("in_ready", in_ready, er);
      chk("out_valid", out_valid, ev);
      chk("frame_done", frame_done, fd_exp);
      chk("sync_err", sync_err, m_serr);
      if (ev) begin
        chk("out_gray", out_gray, q[0].g);
        chk("out_hist", out_hist, q[0].h);
        chk("out_hist_valid", out_hist_valid, q[0].hv);
        chk("out_eof", out_eof, q[0].eof);
        if (ordy) void'(q.pop_front());
      end
    end
    @(posedge clk);
    fd_exp = 1'b0;
    if (!rst_n) begin
      q.delete();
      m_cnt = 0; m_addr = 0; m_serr = 1'b0;
    end else if (a) model_accept(sof, rgb);
    win++;
    #1;
  endtask

  task automatic px(input logic sof, input logic [31:0] rgb, input logic rnd);
    logic a;
    int t = 0;
    do begin
      cyc(rnd ? $urandom_range(0, 3) != 0 : 1'b1, sof, rgb, rnd ? $urandom_range(0, 3) != 0 : 1'b1, a);
      t++;
    end while (!a && t < 50);
    chk("accept_timeout", a, 1'b1);
  endtask

  task automatic frame(input int g, input logic rnd, input logic bp);
    logic a;
    logic [31:0] rgb;
    for (int n = 0; n < 8; n++) begin
      rgb = g < 0 ? $urandom : {8'(g), 8'(g), 8'(g), 8'($urandom)};
      if (bp && n == 3) for (int s = 0; s < 5; s++) cyc(1'b1, 1'b0, rgb, 1'b0, a);
      px(n == 0, rgb, rnd);
    end
  endtask

  task automatic do_reset(input int n);
    logic a;
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, 1'b1, a);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_gray", out_gray, 8'd0);
    chk("rst_out_hist", out_hist, 16'd0);
    chk("rst_hist_valid", out_hist_valid, 2'b00);
    chk("rst_out_eof", out_eof, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_sync_err", sync_err, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    win++;
  endtask

  task automatic drain();
    logic a;
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, '0, 1'b1, a);
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    logic [31:0] conv [5];
    conv = '{32'hFFFFFF00, 32'h00000000, 32'hFF000000, 32'h00FF0000, 32'h0000FF00};
    do_reset(2);
    for (int n = 0; n < 8; n++) px(n == 0, n < 5 ? conv[n] : $urandom, 1'b0);
    drain();
    do_reset(1);
    frame(10, 1'b0, 1'b0);
    frame(20, 1'b1, 1'b0);
    frame(30, 1'b0, 1'b1);
    frame(40, 1'b1, 1'b0);
    for (int n = 0; n < 3; n++) px(n == 0, $urandom, 1'b0);
    px(1'b1, $urandom, 1'b0);
    for (int n = 0; n < 7; n++) px(1'b0, $urandom, 1'b1);
    frame(-1, 1'b1, 1'b0);
    drain();
    do_reset(1);
    frame(-1, 1'b0, 1'b0);
    frame(-1, 1'b1, 1'b0);
    for (int n = 0; n < 5; n++) px(n == 0, $urandom, 1'b0);
    do_reset(1);
    frame(-1, 1'b1, 1'b0);
    frame(-1, 1'b1, 1'b1);
    frame(-1, 1'b1, 1'b0);
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
